// File: rtl/clkgen_pkg.sv
// Shared definitions for the multiphase non-overlapping clock generator:
// default widths, period helpers and the duty clamp rule.
package clkgen_pkg;

   localparam int CNT_W_DEF  = 5;
   localparam int DIV_W_DEF  = 3;
   localparam int NUM_CH_DEF = 2;

   function automatic int unsigned half_of(input int unsigned cnt_w);
      return 32'd1 << (cnt_w - 1);
   endfunction

   function automatic int unsigned max_of(input int unsigned cnt_w);
      return (32'd1 << cnt_w) - 32'd1;
   endfunction

   // Largest width (minus one) that still leaves a low tick on both sides of
   // the complementary window half a period away.
   function automatic int unsigned duty_clamp(input int unsigned duty,
                                              input int unsigned cnt_w);
      int unsigned limit;
      limit = half_of(cnt_w) - 32'd2;
      return (duty > limit) ? limit : duty;
   endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One modulation channel: phase/duty shadows, the window compare against the
// shared down-counter, the clamp flag and the registered MOD/MODN pair.
module clkgen_channel
   import clkgen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] count_next,
   input  logic [CNT_W-1:0] phase_sel,
   input  logic [CNT_W-2:0] duty_sel,
   output logic             mod,
   output logic             modn,
   output logic             clamp
);

   localparam int DW = CNT_W - 1;
   localparam logic [CNT_W-1:0] HALF_V = CNT_W'(half_of(CNT_W));
   localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(half_of(CNT_W) - 2);

   logic [CNT_W-1:0] phase_q;
   logic [CNT_W-1:0] phase_next;
   logic [DW-1:0]    duty_q;
   logic [DW-1:0]    duty_next;
   logic [CNT_W-1:0] d_eff;
   logic [CNT_W-1:0] pos;
   logic [CNT_W-1:0] pos_n;

   // The window is evaluated on the values that will be live after this edge,
   // so a reload at the wrap applies to count MAX without a stale cycle.
   always_comb begin
      phase_next = load ? phase_sel : phase_q;
      duty_next  = load ? duty_sel  : duty_q;
      d_eff      = CNT_W'(duty_clamp(32'(duty_next), CNT_W));
      pos        = phase_next - count_next;
      pos_n      = phase_next - HALF_V - count_next;
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= '0;
         duty_q  <= '0;
         clamp   <= 1'b0;
         mod     <= 1'b0;
         modn    <= 1'b0;
      end else begin
         phase_q <= phase_next;
         duty_q  <= duty_next;
         if (load) begin
            clamp <= ({1'b0, duty_sel} > LIMIT);
         end
         mod  <= en && (pos   <= d_eff);
         modn <= en && (pos_n <= d_eff);
      end
   end

endmodule

// File: rtl/multiphase_nonoverlap_clkgen.sv
// Multi-channel non-overlapping clock generator: shared prescaler and
// down-counter, FREQ_SEL shadow, reference clock and period strobe.
module multiphase_nonoverlap_clkgen
   import clkgen_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input  logic                        CLK_IN,
   input  logic                        RST,
   input  logic                        EN,
   input  logic [DIV_W-1:0]            FREQ_SEL,
   input  logic [NUM_CH*CNT_W-1:0]     PHASE_SEL,
   input  logic [NUM_CH*(CNT_W-1)-1:0] DUTY_SEL,
   output logic [NUM_CH-1:0]           CLK_OUT_MOD,
   output logic [NUM_CH-1:0]           CLK_OUT_MODN,
   output logic                        CLK_OUT_MODL,
   output logic                        PERIOD_STB,
   output logic [NUM_CH-1:0]           DUTY_CLAMP,
   output logic [CNT_W-1:0]            COUNT_OUT
);

   localparam int PRE_W = (1 << DIV_W) - 1;
   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(max_of(CNT_W));

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_mask;
   logic             run_q;
   logic [DIV_W-1:0] freq_q;
   logic             tick;
   logic             wrap;
   logic             load;
   logic [CNT_W-1:0] count_next;

   // run_q delays the first tick by one cycle so that enabling with
   // FREQ_SEL=0 still waits 2^FREQ_SEL cycles before the count moves.
   always_comb begin
      pre_mask   = ~({PRE_W{1'b1}} << freq_q);
      tick       = EN && run_q && ((pre_q & pre_mask) == pre_mask);
      wrap       = tick && (COUNT_OUT == '0);
      load       = !EN || wrap;
      count_next = !EN ? MAX_V : (tick ? COUNT_OUT - CNT_W'(1) : COUNT_OUT);
   end

   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         pre_q        <= '0;
         run_q        <= 1'b0;
         freq_q       <= '0;
         COUNT_OUT    <= MAX_V;
         CLK_OUT_MODL <= 1'b0;
         PERIOD_STB   <= 1'b0;
      end else begin
         run_q <= EN;
         // Restarting the prescaler on each tick keeps the period exact even
         // when a new FREQ_SEL is picked up at the wrap.
         if (!EN || !run_q || tick) begin
            pre_q <= '0;
         end else begin
            pre_q <= pre_q + PRE_W'(1);
         end
         if (load) begin
            freq_q <= FREQ_SEL;
         end
         COUNT_OUT    <= count_next;
         CLK_OUT_MODL <= EN && count_next[CNT_W-1];
         PERIOD_STB   <= wrap;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      clkgen_channel #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk        (CLK_IN),
         .rst        (RST),
         .en         (EN),
         .load       (load),
         .count_next (count_next),
         .phase_sel  (PHASE_SEL[c*CNT_W +: CNT_W]),
         .duty_sel   (DUTY_SEL[c*(CNT_W-1) +: CNT_W-1]),
         .mod        (CLK_OUT_MOD[c]),
         .modn       (CLK_OUT_MODN[c]),
         .clamp      (DUTY_CLAMP[c])
      );
   end

endmodule
